// File: rtl/pot_skew_feeder.sv
// pot_skew_feeder
//   Quantises a beat of N signed 8-bit weights to power-of-two codes and
//   feeds them into a systolic array with a diagonal skew. Column j of a
//   beat appears j cycles after column 0. The first column appears one
//   cycle after the beat is accepted. Slots without an accepted beat
//   travel through the skew as bubbles: code 8'h20 with valid low.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : asynchronous, active-low
//   in_valid   : in_data / in_last carry a beat this cycle
//   in_ready   : block accepts a beat this cycle (registered)
//   in_last    : current beat closes the tile
//   in_data    : N signed weights, column j at [8j+7:8j]
//   col_out    : PoT code per column, column j at [8j+7:8j] (registered)
//   col_valid  : bit j set when column j carries a real weight
//   busy       : tile in progress (STREAM or DRAIN)
//   done       : one-cycle pulse when the last beat leaves column N-1
module pot_skew_feeder #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_last,
  input  logic [8*N-1:0] in_data,
  output logic [8*N-1:0] col_out,
  output logic [N-1:0]   col_valid,
  output logic           busy,
  output logic           done
);

  localparam logic [7:0] BUBBLE = 8'h20;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;

  assign accept = in_valid & in_ready_q;

  // Sign/magnitude PoT code. Magnitude is taken as unsigned 8-bit so that
  // -128 becomes 8'h80 and its leading one (bit 7) clamps to 6.
  function automatic logic [7:0] pot_code(input logic [7:0] w);
    logic [7:0] mag;
    logic [3:0] sh;
    mag = w[7] ? (~w + 8'd1) : w;
    sh  = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (mag[b]) sh = 4'(b);
    end
    if (sh > 4'd6) sh = 4'd6;
    if (w == '0) return BUBBLE;
    return {3'b000, w[7], sh};
  endfunction

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  // DRAIN counts edges since the last beat. The counter reaches N-1 when
  // the last beat is in the final skew register. done is raised on the
  // following edge, which is the same edge that column N-1 presents the
  // code. The FSM leaves DRAIN one edge after done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, STREAM: begin
        if (accept) begin
          state_d = in_last ? DRAIN : STREAM;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (done_q) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_CNT) begin
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d != DRAIN);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // ---------------------------------------------------------------------
  // Per-column skew pipelines
  // ---------------------------------------------------------------------
  // Column j has j+1 stages ahead of its output register. Stage 0 captures
  // the quantised weight, or a bubble, on every edge. This keeps bubbles in
  // lock-step with beats across all columns.
  for (genvar j = 0; j < N; j++) begin : g_col
    logic [7:0] pipe_q [0:j];
    logic [7:0] pipe_d [0:j];
    logic [j:0] vpipe_q, vpipe_d;
    logic [7:0] col_q, col_d;
    logic       col_v_q, col_v_d;

    always_comb begin
      pipe_d[0]  = accept ? pot_code(in_data[8*j +: 8]) : BUBBLE;
      vpipe_d[0] = accept;
      for (int unsigned k = 1; k <= j; k++) begin
        pipe_d[k]  = pipe_q[k-1];
        vpipe_d[k] = vpipe_q[k-1];
      end
      col_d   = pipe_q[j];
      col_v_d = vpipe_q[j];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int unsigned k = 0; k <= j; k++) begin
          pipe_q[k] <= BUBBLE;
        end
        vpipe_q <= '0;
        col_q   <= BUBBLE;
        col_v_q <= 1'b0;
      end else begin
        for (int unsigned k = 0; k <= j; k++) begin
          pipe_q[k] <= pipe_d[k];
        end
        vpipe_q <= vpipe_d;
        col_q   <= col_d;
        col_v_q <= col_v_d;
      end
    end

    assign col_out[8*j +: 8] = col_q;
    assign col_valid[j]      = col_v_q;
  end

endmodule

// File: tb/tb_pot_skew_feeder.sv
module tb_pot_skew_feeder;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_last = 1'b0;
  logic [8*N-1:0] in_data = '0;
  logic [8*N-1:0] col_out;
  logic [N-1:0]   col_valid;
  logic           busy;
  logic           done;

  int n_cmp = 0;
  int n_bad = 0;
  bit sim_done = 0;

  pot_skew_feeder #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .in_data  (in_data),
    .col_out  (col_out),
    .col_valid(col_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference quantiser: plain integer arithmetic
  function automatic logic [7:0] q_model(input logic signed [7:0] w);
    int m, s;
    if (w == 0) return 8'h20;
    m = (w < 0) ? -int'(w) : int'(w);
    s = 0;
    while ((1 << (s + 1)) <= m) s++;
    if (s > 6) s = 6;
    return {3'b000, (w < 0) ? 1'b1 : 1'b0, 4'(s)};
  endfunction

  // ---------------------------------------------------------------
  // Timeline model: h_*[k] is the slot captured k edges ago.
  // Column j at the current cycle shows slot h_*[j+1].
  // The FSM outputs derive from the edge index of the last beat.
  // ---------------------------------------------------------------
  logic [8*N-1:0] h_data [0:N];
  logic           h_val  [0:N];
  logic           m_ready = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  bit             in_stream = 0, l_valid = 0;
  int             e = 0, l_edge = 0;

  initial begin
    for (int k = 0; k <= N; k++) begin h_val[k] = 1'b0; h_data[k] = '0; end
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        for (int k = 0; k <= N; k++) h_val[k] = 1'b0;
        m_ready = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        in_stream = 0; l_valid = 0;
      end else begin
        bit acc;
        acc = in_valid && m_ready;
        for (int k = N; k >= 1; k--) begin
          h_val[k] = h_val[k-1]; h_data[k] = h_data[k-1];
        end
        h_val[0] = acc; h_data[0] = in_data;
        e++;
        if (acc) begin
          if (in_last) begin l_edge = e; l_valid = 1; in_stream = 0; end
          else in_stream = 1;
        end
        m_done  = l_valid && (e == l_edge + N);
        m_ready = !(l_valid && e <= l_edge + N);
        m_busy  = in_stream || (l_valid && e <= l_edge + N);
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge
  initial begin
    forever begin
      logic [8*N-1:0] exp_out;
      logic [N-1:0]   exp_v;
      @(negedge clk);
      if (sim_done) break;
      for (int j = 0; j < N; j++) begin
        exp_v[j] = h_val[j+1];
        exp_out[8*j +: 8] = h_val[j+1] ? q_model(h_data[j+1][8*j +: 8]) : 8'h20;
      end
      chk("col_out", 64'(col_out), 64'(exp_out));
      chk("col_valid", 64'(col_valid), 64'(exp_v));
      chk("in_ready", 64'(in_ready), 64'(m_ready));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
    end
  end

  // One cycle: drive inputs, pass an edge, return 1ns after it
  task automatic step(input logic v, input logic l, input logic [8*N-1:0] d);
    in_valid = v; in_last = l; in_data = d;
    @(posedge clk); #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'($urandom_range(0, 1)), $urandom);
  endtask

  // Single-beat tile with literal code expectations per column
  task automatic lit_tile(input logic [8*N-1:0] data, input logic [8*N-1:0] exp);
    step(1'b1, 1'b1, data);
    for (int j = 0; j < N; j++) begin
      idle_step();
      chk("skew_valid", 64'(col_valid), 64'(1 << j));
      chk("skew_code", 64'(col_out[8*j +: 8]), 64'(exp[8*j +: 8]));
      chk("skew_done", 64'(done), 64'(j == N - 1));
    end
    idle_step();
  endtask

  initial begin
    int rej, v0;
    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col_out", 64'(col_out), 64'h20202020);
    chk("rst_col_valid", 64'(col_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 64'(in_ready), 64'h1);

    // skew {1,2,4,8} -> 00,01,02,03
    lit_tile(32'h08040201, 32'h03020100);
    // quantisation: 0,1,5,-20 -> 20,00,02,14 ; 100,127,-128,0 -> 06,06,16,20
    lit_tile(32'hEC050100, 32'h14020020);
    lit_tile(32'h00807F64, 32'h20160606);

    // back-to-back tiles, next tile offered through DRAIN
    v0 = 0;
    step(1'b1, 1'b0, 32'h11223344); v0 += int'(col_valid[0]);
    step(1'b1, 1'b0, 32'hF0E0D0C0); v0 += int'(col_valid[0]);
    step(1'b1, 1'b1, 32'h01807F00); v0 += int'(col_valid[0]);
    rej = 0;
    while (!in_ready && rej < 20) begin
      step(1'b1, 1'b1, 32'h55AA0381); v0 += int'(col_valid[0]);
      rej++;
    end
    chk("b2b_rejected_cycles", 64'(rej), 64'(N + 1));
    step(1'b1, 1'b1, 32'h55AA0381); v0 += int'(col_valid[0]);
    repeat (N + 2) begin idle_step(); v0 += int'(col_valid[0]); end
    chk("b2b_col0_beats", 64'(v0), 64'd4);

    // bubble in STREAM: valid 1,0,1
    step(1'b1, 1'b0, 32'h00000005);
    idle_step();
    chk("bubble_v0_a", 64'(col_valid[0]), 64'h1);
    step(1'b1, 1'b1, 32'h000000FF);
    chk("bubble_v0_gap", 64'(col_valid[0]), 64'h0);
    chk("bubble_code_gap", 64'(col_out[7:0]), 64'h20);
    idle_step();
    chk("bubble_v0_b", 64'(col_valid[0]), 64'h1);
    chk("bubble_code_b", 64'(col_out[7:0]), 64'h10);
    repeat (N + 1) idle_step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [8*N-1:0] d;
      d = $urandom;
      if ($urandom_range(0, 7) == 0) d[7:0] = 8'h80;
      if ($urandom_range(0, 7) == 0) d[15:8] = 8'h00;
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 4) == 0), d);
    end
    repeat (N + 2) idle_step();

    // reset in the second DRAIN cycle
    step(1'b1, 1'b0, 32'h01020304);
    step(1'b1, 1'b1, 32'h7F7F7F7F);
    in_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("midrst_col_out", 64'(col_out), 64'h20202020);
    chk("midrst_col_valid", 64'(col_valid), 64'h0);
    chk("midrst_done", 64'(done), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    repeat (N + 2) begin
      @(posedge clk); #1;
      chk("midrst_no_done", 64'(done), 64'h0);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready_after", 64'(in_ready), 64'h1);
    repeat (N + 2) begin
      @(posedge clk); #1;
      chk("midrst_still_no_done", 64'(done), 64'h0);
    end

    // a final tile after the mid-tile reset
    lit_tile(32'h08040201, 32'h03020100);

    sim_done = 1;
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global timeout
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
